// File: rtl/fmap_pkg.sv
// Shared defaults, FSM state type and a small width helper for the pixel-stream transmitter.
package fmap_pkg;

  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_IMG_W      = 14;
  localparam int DEF_IMG_H      = 14;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int PIX_COUNT      = DEF_IMG_W * DEF_IMG_H;
  localparam int PAD            = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } fmap_state_e;

  // Counter width for a dimension of n positions (never below one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fmap_ram.sv
// Single-clock 1W/1R feature-map store; read data is registered and only advances on rd_en.
module fmap_ram
  import fmap_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the output register is cleared; the array keeps its contents across reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fmap_stream_tx.sv
// Streams one stored feature map in raster order with eol/eof sideband and a hold stall.
// Define FMAP_STREAM_TX_ZERO_PAD_EN to wrap the frame in a PAD-pixel zero border.
module fmap_stream_tx
  import fmap_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic                  hold,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  eol_out,
  output logic                  eof_out,
  output logic                  busy,
  output logic                  done
);

`ifdef FMAP_STREAM_TX_ZERO_PAD_EN
  localparam int BORDER = PAD;
`else
  localparam int BORDER = 0;
`endif

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int OUT_W = IMG_W + 2 * BORDER;
  localparam int OUT_H = IMG_H + 2 * BORDER;
  localparam int CW    = cnt_w(OUT_W);
  localparam int RW    = cnt_w(OUT_H);

  localparam logic [CW-1:0]         COL_LAST  = CW'(OUT_W - 1);
  localparam logic [RW-1:0]         ROW_LAST  = RW'(OUT_H - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(NPIX - 1);
  localparam logic [ADDR_WIDTH:0]   NPIX_V    = (ADDR_WIDTH + 1)'(NPIX);

  if ((2 ** ADDR_WIDTH) < NPIX) begin : g_bad_cfg
    $error("fmap_stream_tx: ADDR_WIDTH cannot address IMG_W*IMG_H pixels");
  end

  fmap_state_e           state_q, state_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  valid_q, valid_d;
  logic                  eol_q, eol_d;
  logic                  eof_q, eof_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  logic                  issue, last_pix, col_end, interior, wr_ok;
  logic [DATA_WIDTH-1:0] rd_data;

  assign issue    = (state_q == STREAM) && !hold;
  assign col_end  = (col_q == COL_LAST);
  assign last_pix = col_end && (row_q == ROW_LAST);

`ifdef FMAP_STREAM_TX_ZERO_PAD_EN
  localparam logic [RW-1:0] ROW_LO = RW'(BORDER);
  localparam logic [RW-1:0] ROW_HI = RW'(BORDER + IMG_H - 1);
  localparam logic [CW-1:0] COL_LO = CW'(BORDER);
  localparam logic [CW-1:0] COL_HI = CW'(BORDER + IMG_W - 1);

  logic zero_q, zero_d;

  assign interior = (row_q >= ROW_LO) && (row_q <= ROW_HI) &&
                    (col_q >= COL_LO) && (col_q <= COL_HI);

  // Remembers whether the beat now on data_out came from the border; holds with data.
  always_comb begin
    zero_d = zero_q;
    if (issue) zero_d = !interior;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) zero_q <= 1'b0;
    else      zero_q <= zero_d;
  end

  assign data_out = zero_q ? '0 : rd_data;
`else
  assign interior = 1'b1;
  assign data_out = rd_data;
`endif

  // Loads are only accepted between frames and inside the map.
  assign wr_ok = wr_en && (state_q == IDLE) && ({1'b0, wr_addr} < NPIX_V);

  fmap_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (issue && interior),
    .rd_addr (addr_q),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          row_d   = '0;
          col_d   = '0;
          addr_d  = '0;
        end
      end
      STREAM: begin
        if (issue) begin
          if (col_end) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          // RAM address only walks interior pixels and saturates at the last one.
          if (interior && (addr_q != ADDR_LAST)) addr_d = addr_q + 1'b1;
          if (last_pix) begin
            state_d = FLUSH;
            row_d   = '0;
            col_d   = '0;
          end
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    valid_d = issue;
    eol_d   = issue && col_end;
    eof_d   = issue && last_pix;
    done_d  = issue && last_pix;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign valid_out = valid_q;
  assign eol_out   = eol_q;
  assign eof_out   = eof_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fmap_stream_tx.sv
// Directed bench for fmap_stream_tx: frame-level pixel model plus literal anchors per scenario.
module tb_fmap_stream_tx;

  localparam int DW = 24;
  localparam int W  = 14;
  localparam int H  = 14;
  localparam int AW = 8;
`ifdef FMAP_STREAM_TX_ZERO_PAD_EN
  localparam int B        = 2;
  localparam int LOAD_OFS = 1;
`else
  localparam int B        = 0;
  localparam int LOAD_OFS = 0;
`endif
  localparam int OW = W + 2 * B;
  localparam int OH = H + 2 * B;
  localparam int N  = OW * OH;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic [DW-1:0] data_out;
  logic          valid_out, eol_out, eof_out, busy, done;

  fmap_stream_tx dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .hold      (hold),
    .data_out  (data_out),
    .valid_out (valid_out),
    .eol_out   (eol_out),
    .eof_out   (eof_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] g, input logic [63:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, g, e);
    end
  endtask

  // Frame model: what the stored map should be, and which beat of the frame is due.
  logic [DW-1:0] mem_m [W*H];
  bit m_active = 1'b0;
  bit m_flush  = 1'b0;
  bit e_valid  = 1'b0;
  bit e_busy   = 1'b0;
  int m_rem = 0;
  int nb    = 0;
  int e_beat = 0;

  function automatic logic [DW-1:0] exp_pix(input int k);
    int r, c;
    r = k / OW;
    c = k % OW;
    if (r < B || r >= B + H || c < B || c >= B + W) return '0;
    return mem_m[(r - B) * W + (c - B)];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 1'b0; m_flush = 1'b0; m_rem = 0; nb = 0;
      e_valid = 1'b0; e_busy = 1'b0; e_beat = 0;
    end else begin
      bit was_busy;
      was_busy = m_active || m_flush;
      m_flush = 1'b0;
      e_valid = 1'b0;
      if (m_active) begin
        if (!hold) begin
          e_valid = 1'b1;
          e_beat  = nb;
          nb++;
          m_rem--;
          if (m_rem == 0) begin
            m_active = 1'b0;
            m_flush  = 1'b1;
          end
        end
      end else if (!was_busy && start) begin
        m_active = 1'b1;
        m_rem    = N;
        nb       = 0;
      end
      e_busy = m_active || m_flush;
    end
  end

  // Per-scenario observations of the DUT stream.
  bit chk_en = 1'b0;
  int beats = 0, first_v = -1, last_v = -1, done_cnt = 0, busy_fall = -1, t0 = 0;
  logic [DW-1:0] got [N];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", valid_out, e_valid);
      chk("busy", busy, e_busy);
      if (e_valid) begin
        chk("data", data_out, exp_pix(e_beat));
        chk("eol", eol_out, (e_beat % OW) == OW - 1);
        chk("eof", eof_out, e_beat == N - 1);
        chk("done", done, e_beat == N - 1);
      end else begin
        chk("done_idle", done, 1'b0);
      end
      if (valid_out === 1'b1) begin
        if (beats < N) got[beats] = data_out;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        beats++;
        if (done === 1'b1) done_cnt++;
      end
      if (busy === 1'b0 && first_v >= 0 && busy_fall < 0) busy_fall = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic clr();
    beats = 0; first_v = -1; last_v = -1; done_cnt = 0; busy_fall = -1;
  endtask

  task automatic pulse_start();
    start = 1'b1; t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_to(input int c);
    int n;
    n = 0;
    while (cyc < c && n < 3000) begin tick(); n++; end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((m_active || m_flush || e_busy) && n < 3000) begin tick(); n++; end
    chk(nm, n < 3000, 1'b1);
    tick(); tick();
  endtask

  initial begin
    tick(); tick();
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_data", data_out, '0);
    rst = 1'b1;
    tick();
    chk_en = 1'b1;

    // 1: plain frame
    for (int i = 0; i < W * H; i++) begin
      mem_m[i] = DW'(i + LOAD_OFS);
      wr(i, DW'(i + LOAD_OFS));
    end
    wr(200, 24'hABCDEF);
    clr();
    pulse_start();
    wait_idle("t1_timeout");
    chk("t1_first_lat", first_v - t0, 2);
    chk("t1_beats", beats, N);
    chk("t1_last_lat", last_v - t0, N + 1);
    chk("t1_busy_fall", busy_fall - t0, N + 2);
    chk("t1_done_cnt", done_cnt, 1);
`ifdef FMAP_STREAM_TX_ZERO_PAD_EN
    chk("t1_beat37", got[37], 0);
    chk("t1_beat38", got[38], 1);
    chk("t1_beat39", got[39], 2);
    chk("t1_beat51", got[51], 14);
    chk("t1_beat323", got[323], 0);
`else
    chk("t1_pix0", got[0], 0);
    chk("t1_pix13", got[13], 13);
    chk("t1_pix195", got[195], 195);
`endif

    // 2: three-cycle hold right after pixel 50 issues
    clr();
    pulse_start();
    wait_to(t0 + 52);
    hold = 1'b1;
    repeat (3) tick();
    hold = 1'b0;
    wait_idle("t2_timeout");
    chk("t2_beats", beats, N);
    chk("t2_gap", (last_v - first_v + 1) - beats, 3);
    chk("t2_last_lat", last_v - t0, N + 4);
    chk("t2_done_cnt", done_cnt, 1);
`ifndef FMAP_STREAM_TX_ZERO_PAD_EN
    chk("t2_pix50", got[50], 50);
    chk("t2_pix51", got[51], 51);
`endif

    // 3: restart and write while streaming are both ignored
    clr();
    pulse_start();
    wait_to(t0 + 81);
    start = 1'b1; wr_en = 1'b1; wr_addr = AW'(100); wr_data = 24'hFFFFFF;
    tick();
    start = 1'b0; wr_en = 1'b0;
    wait_idle("t3_timeout");
    chk("t3_beats", beats, N);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_busy_fall", busy_fall - t0, N + 2);
`ifdef FMAP_STREAM_TX_ZERO_PAD_EN
    chk("t3_beat100", got[100], 51);
`else
    chk("t3_pix100", got[100], 100);
`endif

    // 4: reset mid-frame, then a fresh frame from stored contents
    clr();
    pulse_start();
    wait_to(t0 + 101);
    rst = 1'b0;
    #1;
    chk("t4_rst_valid", valid_out, 1'b0);
    chk("t4_rst_busy", busy, 1'b0);
    chk("t4_rst_data", data_out, '0);
    chk("t4_rst_eol", eol_out, 1'b0);
    chk("t4_rst_eof", eof_out, 1'b0);
    chk("t4_rst_done", done, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    clr();
    pulse_start();
    wait_idle("t4_timeout");
    chk("t4_beats", beats, N);
    chk("t4_first_lat", first_v - t0, 2);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_first_pix", got[0], exp_pix(0));

    // 5: start arriving with hold high for five cycles
    clr();
    hold = 1'b1;
    pulse_start();
    repeat (4) tick();
    hold = 1'b0;
    wait_idle("t5_timeout");
    chk("t5_first_lat", first_v - t0, 6);
    chk("t5_beats", beats, N);
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_pix0", got[0], 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fmap_stream_tx.md
Name: fmap_stream_tx

Overview:
- Transmitter end of the layer pixel-stream interface.
- Holds one single-channel feature map (default 14x14, the pooled conv1 output) in an internal RAM.
- On start, streams the map in raster order as DATA_WIDTH words with valid_out, feeding the featuremap/conv2d5x5 data_in/valid_in inputs.
- Adds line/frame sideband flags and a hold (stall) input.

Parameters:
- DATA_WIDTH, 24, pixel word width (fixed-point, same format as conv2d5x5).
- IMG_W, 14, pixels per row.
- IMG_H, 14, rows per frame.
- ADDR_WIDTH, 8, RAM address width; must satisfy 2^ADDR_WIDTH >= IMG_W*IMG_H.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  load-port write strobe.
- wr_addr  in  ADDR_WIDTH  load-port address, raster index row*IMG_W+col.
- wr_data  in  DATA_WIDTH  load-port data.
- start  in  1  one-cycle pulse; begin streaming a frame.
- hold  in  1  stall; no new pixel is issued while high.
- data_out  out  DATA_WIDTH  pixel to conv stage.
- valid_out  out  1  data_out qualifier.
- eol_out  out  1  last pixel of a row; meaningful only with valid_out.
- eof_out  out  1  last pixel of the frame; meaningful only with valid_out.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse, coincident with the eof_out beat.

Behaviour:
- Reset (rst low, async): all outputs 0, FSM in IDLE, counters 0. RAM contents are not reset.
- FSM states:
  - IDLE: start moves to STREAM.
  - STREAM: issue = !hold. On each issue, RAM is read at addr, and row/col/addr advance. Col wraps at IMG_W-1 with row++. An issue at the last pixel moves to FLUSH.
  - FLUSH: one cycle, presents the final pixel, then returns to IDLE.
- RAM: 1 write / 1 read, synchronous read, 1-cycle latency.
- Output registers:
  - valid_out, eol_out and eof_out are the issue, col==IMG_W-1 and last-pixel flags, each delayed one cycle.
  - data_out is the RAM read data, updated only when the delayed issue is high; it holds its value otherwise.
- Latency: start in cycle T gives the first valid_out in T+2. With hold low throughout, the frame is IMG_W*IMG_H consecutive valid beats.
- busy: high from T+1 through the FLUSH cycle inclusive.
- done: equals eof_out gated by valid_out.
- hold:
  - Affects only issue. A pixel already read is still presented the next cycle, so valid_out deasserts exactly one cycle after hold rises and reasserts one cycle after it falls.
  - No pixel is lost or duplicated.
  - hold in FLUSH has no effect.
- Simultaneous / boundary events:
  - start while busy: ignored.
  - start together with hold: enters STREAM, first issue waits for hold low.
  - wr_en while busy: write dropped; the streaming frame is never corrupted.
  - wr_en while IDLE: writes the RAM, no other effect.
  - wr_addr >= IMG_W*IMG_H: write dropped.
  - Reset mid-frame: immediate return to the reset state; the next start restarts at pixel 0.
- Arithmetic: the addr counter is ADDR_WIDTH bits wide, compared against IMG_W*IMG_H-1, never wraps past it. Row and col counters are each ceil(log2) of their dimension.

Optional Feature:
- Macro FMAP_STREAM_TX_ZERO_PAD_EN.
- Defined:
  - Frame is extended with a 2-pixel zero border ("same" padding for a 5x5 kernel), giving (IMG_W+4)x(IMG_H+4) beats (18x18 = 324 by default).
  - Border beats output 0 and do not read the RAM.
  - Interior pixel (r+2, c+2) = RAM[r*IMG_W+c].
  - eol_out and eof_out refer to the padded dimensions; latency and hold rules are unchanged.
- Undefined: unpadded IMG_W*IMG_H frame as above.

Decomposition:
- Package fmap_pkg:
  - DATA_WIDTH, IMG_W, IMG_H, ADDR_WIDTH defaults.
  - PIX_COUNT = IMG_W*IMG_H.
  - PAD = 2.
  - FSM state enum {IDLE, STREAM, FLUSH}.
- Sub-module fmap_ram: single-clock 1W/1R synchronous-read RAM, DATA_WIDTH x 2^ADDR_WIDTH. The FSM, counters and output registers stay in fmap_stream_tx.

Test Plan:
- Load RAM[i]=i for i=0..195, pulse start at T: valid_out high T+2..T+197 with data 0..195; eol_out on data 13,27,...,195; eof_out, done only on 195; busy low at T+198.
- Stream with hold high for 3 cycles after pixel 50 is issued: valid_out has exactly a 3-cycle gap; data sequence still 0..195 with no repeats.
- start pulsed again at pixel 80 plus wr_en to addr 100 with 0xFFFFFF: frame continues unchanged (pixel 100 = 100); exactly one done.
- Assert rst low at pixel 100: outputs 0 the same cycle; after release, start gives 0..195 again (RAM retained).
- start with hold held high 5 cycles: busy=1, valid_out=0 until 1 cycle after hold falls, then data 0 first.
- Macro defined, RAM[i]=i+1: 324 beats; beats 0..37 and all border beats are 0; beat 38 (row 2, col 2) = 1; eof_out on beat 323.
